// File: rtl/pc_redirect_unit_if.sv
// Request/response bundle between the pipeline control and the PC redirect unit.
// The master side raises stalls and redirect requests. The slave side is the
// PC unit, which returns the fetch address, the resolution-stage link value and
// the flush/misalign strobes.
interface pc_redirect_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             redirect_valid;
    logic             redirect_mode;
    logic [WIDTH-1:0] redirect_addr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_res;
    logic             res_valid;
    logic             flush;
    logic             misalign;

    modport master (
        output stall, redirect_valid, redirect_mode, redirect_addr,
        input  pc, pc_res, res_valid, flush, misalign
    );

    modport slave (
        input  stall, redirect_valid, redirect_mode, redirect_addr,
        output pc, pc_res, res_valid, flush, misalign
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// Program-counter unit for the five-stage pipeline.
// It produces the fetch PC and carries each instruction's link value (PC+INC)
// and valid bit down to RES_STAGE. A redirect that arrives from a valid
// instruction in that stage is taken two edges later. The one wrong-path fetch
// in between is marked invalid.
module pc_redirect_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               RES_STAGE = 3,
    parameter int               INC       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_redirect_unit_if.slave    bus
);
    localparam int               DEPTH    = RES_STAGE - 1;
    localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INC - 1);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             pend_q, pend_d;
    logic             mis_q, mis_d;
    logic [WIDTH-1:0] lnk_q [DEPTH];
    logic [WIDTH-1:0] lnk_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;

    logic             accept;
    logic             flush_w;
    logic [WIDTH-1:0] raw_target;

    // Next-state logic: accept a redirect, advance the fetch PC and shift the link/valid pipeline
    always_comb begin
        pc_d       = pc_q;
        target_d   = target_q;
        pend_d     = pend_q;
        mis_d      = mis_q;
        lnk_d      = lnk_q;
        vld_d      = vld_q;
        accept     = bus.redirect_valid & vld_q[DEPTH-1] & ~pend_q & ~bus.stall;
        raw_target = bus.redirect_mode ? bus.redirect_addr
                                       : (lnk_q[DEPTH-1] + bus.redirect_addr);

        if (!bus.stall) begin
            lnk_d[0] = pc_q + INC_W;
            vld_d[0] = ~pend_q & ~accept;
            for (int k = 1; k < DEPTH; k++) begin
                lnk_d[k] = lnk_q[k-1];
                vld_d[k] = vld_q[k-1] & ~accept;
            end

            if (pend_q) begin
                pc_d   = target_q;
                pend_d = 1'b0;
            end else begin
                pc_d = pc_q + INC_W;
            end

            if (accept) begin
                pend_d   = 1'b1;
                target_d = raw_target & ~LOW_MASK;
                mis_d    = |(raw_target & LOW_MASK);
            end
        end
    end

    // State registers; reset discards any pending redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            target_q <= '0;
            pend_q   <= 1'b0;
            mis_q    <= 1'b0;
            vld_q    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                lnk_q[k] <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            target_q <= target_d;
            pend_q   <= pend_d;
            mis_q    <= mis_d;
            vld_q    <= vld_d;
            for (int k = 0; k < DEPTH; k++) begin
                lnk_q[k] <= lnk_d[k];
            end
        end
    end

    assign flush_w       = pend_q & ~bus.stall;
    assign bus.flush     = flush_w;
    assign bus.misalign  = flush_w & mis_q;
    assign bus.pc        = pc_q;
    assign bus.pc_res    = lnk_q[DEPTH-1];
    assign bus.res_valid = vld_q[DEPTH-1];
endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit (RES_STAGE=3, INC=4, RESET_PC=0).
// The driver applies one cycle of inputs and queues the hand-computed outputs
// for that cycle. The monitor pops one entry at each falling edge and compares it.
module tb_pc_redirect_unit;
    logic clk;
    logic rst_n;

    pc_redirect_unit_if #(.WIDTH(32)) bus ();

    pc_redirect_unit #(
        .WIDTH(32), .RESET_PC(32'h0), .RES_STAGE(3), .INC(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [31:0] pc_res;
        logic        res_valid;
        logic        flush;
        logic        misalign;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_id   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and update the counts
    task automatic check_output(input string name, input int id,
                                input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s[%0d]: got %h expected %h", name, id, act, exp);
    endtask

    // Drive one cycle of inputs, queue its expected outputs, then advance past the next edge
    task automatic apply_stimulus(input logic rv, input logic mode, input logic [31:0] addr,
                                  input logic st, input logic [31:0] e_pc,
                                  input logic [31:0] e_res, input logic e_rv,
                                  input logic e_fl, input logic e_mis);
        exp_t e;
        bus.redirect_valid = rv;
        bus.redirect_mode  = mode;
        bus.redirect_addr  = addr;
        bus.stall          = st;
        e.id = cyc_id; e.pc = e_pc; e.pc_res = e_res;
        e.res_valid = e_rv; e.flush = e_fl; e.misalign = e_mis;
        exp_q.push_back(e);
        cyc_id++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT outputs with the oldest queued expectation on each falling edge
    always @(negedge clk) begin
        exp_t m;
        if (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            check_output("pc",        m.id, bus.pc,                m.pc);
            check_output("pc_res",    m.id, bus.pc_res,            m.pc_res);
            check_output("res_valid", m.id, 32'(bus.res_valid),    32'(m.res_valid));
            check_output("flush",     m.id, 32'(bus.flush),        32'(m.flush));
            check_output("misalign",  m.id, 32'(bus.misalign),     32'(m.misalign));
        end
    end

    // Global watchdog so the run always terminates
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n              = 1'b0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_mode  = 1'b0;
        bus.redirect_addr  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Sequential fetch, then relative redirect +0x20 with redirect_valid held high afterwards
        //             rv mode addr          st  pc            pc_res        rv fl mis
        apply_stimulus(0, 0, 32'h0,          0, 32'h0000_0000, 32'h0000_0000, 0, 0, 0); // c0
        apply_stimulus(0, 0, 32'h0,          0, 32'h0000_0004, 32'h0000_0000, 0, 0, 0); // c1
        apply_stimulus(1, 0, 32'h20,         0, 32'h0000_0008, 32'h0000_0004, 1, 0, 0); // c2
        apply_stimulus(1, 0, 32'h20,         0, 32'h0000_000C, 32'h0000_0008, 0, 1, 0); // c3
        apply_stimulus(1, 0, 32'h20,         0, 32'h0000_0024, 32'h0000_000C, 0, 0, 0); // c4
        apply_stimulus(1, 0, 32'h20,         0, 32'h0000_0028, 32'h0000_0010, 0, 0, 0); // c5
        apply_stimulus(0, 0, 32'h0,          0, 32'h0000_002C, 32'h0000_0028, 1, 0, 0); // c6
        // Absolute misaligned redirect to 0x103
        apply_stimulus(1, 1, 32'h103,        0, 32'h0000_0030, 32'h0000_002C, 1, 0, 0); // c7
        apply_stimulus(0, 0, 32'h0,          0, 32'h0000_0034, 32'h0000_0030, 0, 1, 1); // c8
        apply_stimulus(0, 0, 32'h0,          0, 32'h0000_0100, 32'h0000_0034, 0, 0, 0); // c9
        apply_stimulus(0, 0, 32'h0,          0, 32'h0000_0104, 32'h0000_0038, 0, 0, 0); // c10
        // Relative +0x10 from pc_res 0x104, then a 3-cycle stall over the pending cycle
        apply_stimulus(1, 0, 32'h10,         0, 32'h0000_0108, 32'h0000_0104, 1, 0, 0); // c11
        apply_stimulus(0, 0, 32'h0,          1, 32'h0000_010C, 32'h0000_0108, 0, 0, 0); // c12
        apply_stimulus(1, 1, 32'h300,        1, 32'h0000_010C, 32'h0000_0108, 0, 0, 0); // c13
        apply_stimulus(0, 0, 32'h0,          1, 32'h0000_010C, 32'h0000_0108, 0, 0, 0); // c14
        apply_stimulus(0, 0, 32'h0,          0, 32'h0000_010C, 32'h0000_0108, 0, 1, 0); // c15
        apply_stimulus(0, 0, 32'h0,          0, 32'h0000_0114, 32'h0000_010C, 0, 0, 0); // c16
        apply_stimulus(0, 0, 32'h0,          0, 32'h0000_0118, 32'h0000_0110, 0, 0, 0); // c17
        // Absolute redirect to 0x200, killed by an async reset during its pending cycle
        apply_stimulus(1, 1, 32'h200,        0, 32'h0000_011C, 32'h0000_0118, 1, 0, 0); // c18

        bus.redirect_valid = 1'b0;
        bus.redirect_mode  = 1'b0;
        bus.redirect_addr  = '0;
        #2;
        check_output("pend_flush", cyc_id, 32'(bus.flush), 32'd1);
        check_output("pend_pc",    cyc_id, bus.pc,         32'h0000_0120);
        rst_n = 1'b0;
        #1;
        check_output("rst_pc",     cyc_id, bus.pc,            32'h0);
        check_output("rst_flush",  cyc_id, 32'(bus.flush),    32'd0);
        check_output("rst_rvalid", cyc_id, 32'(bus.res_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Restart from 0, then relative redirect -8 from pc_res 4 and wrap past 0xFFFFFFFC
        apply_stimulus(0, 0, 32'h0,          0, 32'h0000_0000, 32'h0000_0000, 0, 0, 0);
        apply_stimulus(0, 0, 32'h0,          0, 32'h0000_0004, 32'h0000_0000, 0, 0, 0);
        apply_stimulus(1, 0, 32'hFFFF_FFF8,  0, 32'h0000_0008, 32'h0000_0004, 1, 0, 0);
        apply_stimulus(0, 0, 32'h0,          0, 32'h0000_000C, 32'h0000_0008, 0, 1, 0);
        apply_stimulus(0, 0, 32'h0,          0, 32'hFFFF_FFFC, 32'h0000_000C, 0, 0, 0);
        apply_stimulus(0, 0, 32'h0,          0, 32'h0000_0000, 32'h0000_0010, 0, 0, 0);
        apply_stimulus(0, 0, 32'h0,          0, 32'h0000_0004, 32'h0000_0000, 1, 0, 0);
        apply_stimulus(0, 0, 32'h0,          0, 32'h0000_0008, 32'h0000_0004, 1, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
